// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - RAW stall scoreboard and taken-branch flush sequencer
module hazard_scoreboard_ctrl #(
    parameter int REG_IDX_W    = 5,
    parameter int WB_LATENCY   = 3,
    parameter int BRANCH_STAGE = 1,
    parameter int FLUSH_DEPTH  = 3,
    parameter int CNT_W        = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   issue_valid,
    input  logic [REG_IDX_W-1:0]   issue_rs,
    input  logic                   issue_rs_used,
    input  logic [REG_IDX_W-1:0]   issue_rt,
    input  logic                   issue_rt_used,
    input  logic                   issue_wr_en,
    input  logic [REG_IDX_W-1:0]   issue_rd,
    input  logic                   branch_taken,
    output logic                   issue_accept,
    output logic                   stall,
    output logic                   hazard_raw,
    output logic [FLUSH_DEPTH-1:0] flush_phase,
    output logic                   flush_busy,
    output logic [CNT_W-1:0]       raw_stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    logic [WB_LATENCY-1:0]                slot_vld_q, slot_vld_d;
    logic [WB_LATENCY-1:0][REG_IDX_W-1:0] slot_rd_q, slot_rd_d;
    logic [FLUSH_DEPTH-1:0]               flush_phase_q, flush_phase_d;
    logic [CNT_W-1:0]                     raw_stall_cnt_q, raw_stall_cnt_d;
    logic [CNT_W-1:0]                     flush_cnt_q, flush_cnt_d;
    logic                                 slot_hit;

    always_comb begin
        slot_hit = 1'b0;
        for (int s = 0; s < WB_LATENCY; s++) begin
            if (slot_vld_q[s] && (slot_rd_q[s] != '0)) begin
                if ((issue_rs_used && (slot_rd_q[s] == issue_rs)) ||
                    (issue_rt_used && (slot_rd_q[s] == issue_rt))) begin
                    slot_hit = 1'b1;
                end
            end
        end
    end

    assign hazard_raw    = issue_valid & slot_hit;
    assign flush_busy    = |flush_phase_q;
    assign stall         = hazard_raw & ~flush_busy & ~branch_taken;
    assign issue_accept  = issue_valid & ~hazard_raw & ~flush_busy & ~branch_taken;
    assign flush_phase   = flush_phase_q;
    assign raw_stall_cnt = raw_stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

    // Slots younger than the resolving branch lose their writes when it is taken.
    always_comb begin
        slot_vld_d    = '0;
        slot_rd_d     = slot_rd_q;
        slot_vld_d[0] = issue_accept & issue_wr_en & (issue_rd != '0) & ~branch_taken;
        slot_rd_d[0]  = issue_rd;
        for (int i = 1; i < WB_LATENCY; i++) begin
            slot_vld_d[i] = slot_vld_q[i-1] & ~(branch_taken && (i <= BRANCH_STAGE));
            slot_rd_d[i]  = slot_rd_q[i-1];
        end
    end

    always_comb begin
        flush_phase_d   = branch_taken ? FLUSH_DEPTH'(1) : (flush_phase_q << 1);
        raw_stall_cnt_d = raw_stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (stall && (raw_stall_cnt_q != '1)) begin
            raw_stall_cnt_d = raw_stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_vld_q      <= '0;
            slot_rd_q       <= '0;
            flush_phase_q   <= '0;
            raw_stall_cnt_q <= '0;
            flush_cnt_q     <= '0;
        end else begin
            slot_vld_q      <= slot_vld_d;
            slot_rd_q       <= slot_rd_d;
            flush_phase_q   <= flush_phase_d;
            raw_stall_cnt_q <= raw_stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb/tb_hazard_scoreboard_ctrl.sv - randomized and directed checks against an in-flight write list model
module tb_hazard_scoreboard_ctrl;

    localparam int WB = 3;
    localparam int BS = 1;
    localparam int FD = 3;

    logic       clock;
    logic       reset_n;
    logic       issue_valid, issue_rs_used, issue_rt_used, issue_wr_en, branch_taken;
    logic [4:0] issue_rs, issue_rt, issue_rd;

    logic        issue_accept, stall, hazard_raw, flush_busy;
    logic [2:0]  flush_phase;
    logic [15:0] raw_stall_cnt, flush_cnt;

    logic        sat_accept, sat_stall, sat_hazard, sat_busy;
    logic [2:0]  sat_phase;
    logic [1:0]  sat_raw_cnt, sat_flush_cnt;

    hazard_scoreboard_ctrl u_dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
        .issue_rt(issue_rt), .issue_rt_used(issue_rt_used), .issue_wr_en(issue_wr_en),
        .issue_rd(issue_rd), .branch_taken(branch_taken),
        .issue_accept(issue_accept), .stall(stall), .hazard_raw(hazard_raw),
        .flush_phase(flush_phase), .flush_busy(flush_busy),
        .raw_stall_cnt(raw_stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_scoreboard_ctrl #(.CNT_W(2)) u_sat (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
        .issue_rt(issue_rt), .issue_rt_used(issue_rt_used), .issue_wr_en(issue_wr_en),
        .issue_rd(issue_rd), .branch_taken(branch_taken),
        .issue_accept(sat_accept), .stall(sat_stall), .hazard_raw(sat_hazard),
        .flush_phase(sat_phase), .flush_busy(sat_busy),
        .raw_stall_cnt(sat_raw_cnt), .flush_cnt(sat_flush_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of pending writes tagged with the edge they were accepted on.
    typedef struct { int rd; int born; } wr_t;
    wr_t m_wr[$];
    int  m_edges      = 0;
    int  m_flush_left = 0;
    int  m_raw        = 0;
    int  m_flushes    = 0;

    function automatic int m_slot(input wr_t w);
        return m_edges - w.born - 1;
    endfunction

    function automatic bit m_hazard();
        if (!issue_valid) return 1'b0;
        foreach (m_wr[i]) begin
            if ((issue_rs_used && m_wr[i].rd == int'(issue_rs)) ||
                (issue_rt_used && m_wr[i].rd == int'(issue_rt))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_busy();
        return m_flush_left > 0;
    endfunction

    function automatic int m_phase();
        return m_busy() ? (1 << (FD - m_flush_left)) : 0;
    endfunction

    function automatic bit m_accept();
        return issue_valid && !m_hazard() && !m_busy() && !branch_taken;
    endfunction

    function automatic bit m_stall();
        return m_hazard() && !m_busy() && !branch_taken;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_wr.delete();
            m_edges      = 0;
            m_flush_left = 0;
            m_raw        = 0;
            m_flushes    = 0;
        end else begin
            bit acc;
            acc = m_accept();
            if (m_stall()) m_raw++;
            if (branch_taken) begin
                m_flushes++;
                for (int i = m_wr.size() - 1; i >= 0; i--)
                    if (m_slot(m_wr[i]) < BS) m_wr.delete(i);
            end
            if (acc && issue_wr_en && issue_rd != 0) m_wr.push_back('{int'(issue_rd), m_edges});
            m_edges++;
            for (int i = m_wr.size() - 1; i >= 0; i--)
                if (m_slot(m_wr[i]) >= WB) m_wr.delete(i);
            if (branch_taken) m_flush_left = FD;
            else if (m_flush_left > 0) m_flush_left--;
        end
    end

    always @(negedge clock) begin
        chk("hazard_raw", int'(hazard_raw), int'(m_hazard()));
        chk("stall", int'(stall), int'(m_stall()));
        chk("issue_accept", int'(issue_accept), int'(m_accept()));
        chk("flush_phase", int'(flush_phase), m_phase());
        chk("flush_busy", int'(flush_busy), int'(m_busy()));
        chk("raw_stall_cnt", int'(raw_stall_cnt), sat(m_raw, 65535));
        chk("flush_cnt", int'(flush_cnt), sat(m_flushes, 65535));
        chk("sat_accept", int'(sat_accept), int'(m_accept()));
        chk("sat_raw_cnt", int'(sat_raw_cnt), sat(m_raw, 3));
        chk("sat_flush_cnt", int'(sat_flush_cnt), sat(m_flushes, 3));
    end

    task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input bit we, input int rd, input bit br);
        issue_valid   = v;
        issue_rs      = 5'(rs);
        issue_rs_used = rsu;
        issue_rt      = 5'(rt);
        issue_rt_used = rtu;
        issue_wr_en   = we;
        issue_rd      = 5'(rd);
        branch_taken  = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic dep_seq(input int r, input string tag);
        drive(1, 0, 0, 0, 0, 1, r, 0);
        settle(); chk({tag, "_accept_wr"}, int'(issue_accept), 1);
        tick();
        drive(1, r, 1, r, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            settle(); chk({tag, "_stall"}, int'(stall), 1);
            tick();
        end
        settle(); chk({tag, "_accept_dep"}, int'(issue_accept), 1);
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_phase", int'(flush_phase), 0);
        chk("reset_accept", int'(issue_accept), 0);
        chk("reset_cnt", int'(raw_stall_cnt), 0);
        reset_n = 1'b1;

        dep_seq(1, "t1");
        chk("t1_raw_cnt", int'(raw_stall_cnt), 3);

        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 0, 1, 1, 0, 0);
            settle();
            chk("t2_accept", int'(issue_accept), 1);
            chk("t2_stall", int'(stall), 0);
            tick();
        end
        chk("t2_raw_cnt", int'(raw_stall_cnt), 3);
        chk("t2_flush_cnt", int'(flush_cnt), 0);

        drive(1, 0, 0, 0, 0, 1, 4, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 1, 5, 0); tick();
        drive(1, 0, 0, 0, 0, 1, 6, 1);
        settle(); chk("t3_accept_br", int'(issue_accept), 0);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3_phase", int'(flush_phase), 1 << k);
            chk("t3_accept_flush", int'(issue_accept), 0);
            tick();
        end
        settle();
        chk("t3_phase_done", int'(flush_phase), 0);
        chk("t3_no_stall_r5", int'(stall), 0);
        chk("t3_accept_r5", int'(issue_accept), 1);
        chk("t3_flush_cnt", int'(flush_cnt), 1);
        tick();

        drive(1, 0, 0, 0, 0, 1, 7, 0); tick();
        drive(1, 7, 1, 0, 0, 0, 0, 1);
        settle();
        chk("t4_stall", int'(stall), 0);
        chk("t4_accept", int'(issue_accept), 0);
        chk("t4_hazard", int'(hazard_raw), 1);
        tick();
        idle();
        settle();
        chk("t4_raw_cnt", int'(raw_stall_cnt), 3);
        chk("t4_flush_cnt", int'(flush_cnt), 2);
        repeat (3) tick();

        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        idle();
        settle(); chk("t5_phase1", int'(flush_phase), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        settle(); chk("t5_phase2", int'(flush_phase), 2);
        tick();
        idle();
        settle();
        chk("t5_restart", int'(flush_phase), 1);
        chk("t5_flush_cnt", int'(flush_cnt), 2);
        repeat (3) tick();
        settle(); chk("t5_done", int'(flush_busy), 0);
        tick();

        do_reset();
        drive(1, 0, 0, 0, 0, 1, 9, 0); tick();
        idle(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 9, 1, 0, 0, 0, 0, 0);
        settle();
        chk("t6_hazard_pre", int'(hazard_raw), 1);
        chk("t6_phase_pre", int'(flush_phase), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_async_phase", int'(flush_phase), 0);
        chk("t6_async_busy", int'(flush_busy), 0);
        chk("t6_async_hazard", int'(hazard_raw), 0);
        tick();
        reset_n = 1'b1;
        idle();
        tick();

        do_reset();
        dep_seq(2, "t7a");
        dep_seq(3, "t7b");
        chk("t7_raw_cnt", int'(raw_stall_cnt), 6);
        chk("t7_sat_raw_cnt", int'(sat_raw_cnt), 3);

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 8);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
